rtc_display_scan: RTL and testbench

RTC_DISPLAY_SCAN -- requirements
Module: rtc_display_scan

---
 rtl/rtc_display_scan_if.sv | 22 ++
 rtl/rtc_display_scan.sv | 138 +++++++++++++
 tb/tb_rtc_display_scan.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_display_scan_if.sv
// Time-of-day load bus and multiplexed 7-segment display drive for rtc_display_scan.
interface rtc_display_scan_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       err;

  modport master (
    output seconds, minutes, hours, load, blank_lz,
    input  seg, dp, an, err
  );

  modport slave (
    input  seconds, minutes, hours, load, blank_lz,
    output seg, dp, an, err
  );
endinterface

// File: rtl/rtc_display_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment scanner with range-checked snapshot load,
// per-slot blanking and optional hours leading-zero suppression.
module rtc_display_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  rtc_display_scan_if.slave bus
);

  localparam logic [15:0] LAST_CNT   = 16'(SCAN_DIV - 1);
  localparam logic [15:0] LATCH_CNT  = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] LIT_START  = 16'(BLANK_CYCLES);

  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q,  hr_d;
  logic             err_q, err_d;
  logic [5:0][3:0]  bcd_q, bcd_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       dig_q, dig_d;
  logic             in_range;
  logic             lit;
  logic             lz_blank;
  logic             show;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Snapshot capture: all-or-nothing on a range-checked load; err tracks the latest load.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    err_d    = err_q;
    in_range = (bus.seconds <= 6'd59) && (bus.minutes <= 6'd59) && (bus.hours <= 5'd23);
    if (bus.load) begin
      if (in_range) begin
        sec_d = bus.seconds;
        min_d = bus.minutes;
        hr_d  = bus.hours;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // BCD split of the snapshot, indexed by display digit position.
  always_comb begin
    bcd_d    = '0;
    bcd_d[0] = units_of(sec_q);
    bcd_d[1] = tens_of(sec_q);
    bcd_d[2] = units_of(min_q);
    bcd_d[3] = tens_of(min_q);
    bcd_d[4] = units_of({1'b0, hr_q});
    bcd_d[5] = tens_of({1'b0, hr_q});
  end

  // Slot timing and digit index; the shown digit is frozen on the last blank cycle
  // so a load landing mid-window cannot disturb the current slot.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    dig_d = dig_q;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (cnt_q == LATCH_CNT) begin
      dig_d = bcd_q[idx_q];
    end
  end

  // Output decode straight from registers so reset clears the drive without a clock.
  always_comb begin
    lit      = (cnt_q >= LIT_START);
    lz_blank = bus.blank_lz && (idx_q == 3'd5) && (dig_q == 4'd0);
    show     = lit && !lz_blank;
    bus.an   = show ? (6'd1 << idx_q) : '0;
    bus.seg  = show ? seg_enc(dig_q) : '0;
    bus.dp   = show && ((idx_q == 3'd2) || (idx_q == 3'd4));
    bus.err  = err_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
      err_q <= 1'b0;
      bcd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      dig_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
      err_q <= err_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dig_q <= dig_d;
    end
  end

endmodule

// File: tb/tb_rtc_display_scan.sv
// Scoreboard bench for rtc_display_scan: expected per-slot display pushed when
// stimulus is queued, popped and compared as each slot is observed.
module tb_rtc_display_scan;
  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
  } ld_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rtc_display_scan_if bus();

  rtc_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         failures = 0;
  logic [6:0] enc [10];
  ld_t        ld_q [$];
  int         ld_at = 0;
  logic [15:0] sb [$];
  int         m_s, m_m, m_h, exp_idx;
  logic       m_err;

  function automatic logic [15:0] make_exp(input int idx);
    int d;
    logic [5:0] an;
    case (idx)
      0: d = m_s % 10;
      1: d = m_s / 10;
      2: d = m_m % 10;
      3: d = m_m / 10;
      4: d = m_h % 10;
      default: d = m_h / 10;
    endcase
    if (idx == 5 && bus.blank_lz && d == 0) return {2'b11, 14'h0};
    an = 6'd1 << idx;
    return {2'b11, an, enc[d], (idx == 2 || idx == 4)};
  endfunction

  task automatic push_slots(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(make_exp(exp_idx));
      exp_idx = (exp_idx + 1) % 6;
    end
  endtask

  task automatic queue_load(input int s, input int m, input int h);
    ld_q.push_back(ld_t'{6'(s), 6'(m), 5'(h)});
    if (s <= 59 && m <= 59 && h <= 23) begin
      m_s = s; m_m = m; m_h = h; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Watches one slot from its count-0 negedge; drives queued loads from cycle ld_at.
  // obs = {blank cycles clean, lit window stable, an, seg, dp of first lit cycle}.
  task automatic observe_slot(output logic [15:0] obs);
    logic [13:0] first;
    logic [13:0] cur;
    logic bok, stab;
    ld_t l;
    bok = 1'b1; stab = 1'b1; first = '0;
    for (int c = 0; c < int'(SD); c++) begin
      cur = {bus.an, bus.seg, bus.dp};
      if (c < int'(BC)) begin
        if (cur !== 14'h0) bok = 1'b0;
      end else if (c == int'(BC)) begin
        first = cur;
      end else if (cur !== first) begin
        stab = 1'b0;
      end
      if (ld_q.size() > 0 && c >= ld_at) begin
        l = ld_q.pop_front();
        bus.seconds = l.s; bus.minutes = l.m; bus.hours = l.h; bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    obs = {bok, stab, first};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_s = 0; m_m = 0; m_h = 0; m_err = 1'b0; exp_idx = 0;
    sb.delete();
    ld_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.an !== 6'h0) begin failures++; $display("FAIL reset_an got=%h exp=00", bus.an); end
    checks++; if (bus.seg !== 7'h0) begin failures++; $display("FAIL reset_seg got=%h exp=00", bus.seg); end
    checks++; if (bus.dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", bus.dp); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    do_reset();
  endtask

  task automatic test_scan();
    logic [15:0] obs, e;
    push_slots(7);
    for (int i = 0; i < 7; i++) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL scan slot%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_load();
    logic [15:0] obs, e;
    ld_at = 3;
    push_slots(1);
    queue_load(58, 59, 23);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL load slot got=%h exp=%h", obs, e); end
    end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_range_error();
    logic [15:0] obs, e;
    ld_at = 2;
    push_slots(1);
    queue_load(56, 34, 12);
    push_slots(1);
    queue_load(60, 34, 12);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL range slot got=%h exp=%h", obs, e); end
    end
    checks++; if (bus.err !== m_err) begin failures++; $display("FAIL range_err_set got=%b exp=%b", bus.err, m_err); end
    push_slots(1);
    queue_load(3, 2, 1);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL range_recover slot got=%h exp=%h", obs, e); end
    end
    checks++; if (bus.err !== m_err) begin failures++; $display("FAIL range_err_clear got=%b exp=%b", bus.err, m_err); end
  endtask

  task automatic test_leading_zero();
    logic [15:0] obs, e;
    ld_at = 4;
    bus.blank_lz = 1'b1;
    push_slots(1);
    queue_load(0, 0, 7);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL lz_on slot got=%h exp=%h", obs, e); end
    end
    bus.blank_lz = 1'b0;
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL lz_off slot got=%h exp=%h", obs, e); end
    end
  endtask

  task automatic test_mid_slot();
    logic [15:0] obs, e;
    do_reset();
    ld_at = 4;
    push_slots(1);
    queue_load(11, 11, 11);
    push_slots(2);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL mid_slot got=%h exp=%h", obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] obs, e;
    ld_at = 2;
    push_slots(1);
    queue_load(30, 20, 10);
    queue_load(5, 43, 21);
    queue_load(0, 0, 24);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_a slot got=%h exp=%h", obs, e); end
    end
    checks++; if (bus.err !== m_err) begin failures++; $display("FAIL b2b_err_set got=%b exp=%b", bus.err, m_err); end
    ld_at = 5;
    push_slots(1);
    queue_load(1, 1, 1);
    queue_load(9, 8, 7);
    push_slots(6);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_b slot got=%h exp=%h", obs, e); end
    end
    checks++; if (bus.err !== m_err) begin failures++; $display("FAIL b2b_err_clear got=%b exp=%b", bus.err, m_err); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs, e;
    ld_at = 1;
    push_slots(1);
    queue_load(0, 61, 5);
    observe_slot(obs);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rst_pre slot got=%h exp=%h", obs, e); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL rst_pre_err got=%b exp=1", bus.err); end
    repeat (4) @(negedge clk);
    checks++; if (bus.an === 6'h0) begin failures++; $display("FAIL rst_pre_lit got=%h exp=nonzero", bus.an); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.an !== 6'h0) begin failures++; $display("FAIL rst_mid_an got=%h exp=00", bus.an); end
    checks++; if (bus.seg !== 7'h0) begin failures++; $display("FAIL rst_mid_seg got=%h exp=00", bus.seg); end
    checks++; if (bus.dp !== 1'b0) begin failures++; $display("FAIL rst_mid_dp got=%b exp=0", bus.dp); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%b exp=0", bus.err); end
    do_reset();
    push_slots(2);
    while (sb.size() > 0) begin
      observe_slot(obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL rst_restart slot got=%h exp=%h", obs, e); end
    end
  endtask

  initial begin
    enc[0] = 7'h3F; enc[1] = 7'h06; enc[2] = 7'h5B; enc[3] = 7'h4F; enc[4] = 7'h66;
    enc[5] = 7'h6D; enc[6] = 7'h7D; enc[7] = 7'h07; enc[8] = 7'h7F; enc[9] = 7'h6F;
    bus.seconds = '0; bus.minutes = '0; bus.hours = '0;
    bus.load = 1'b0; bus.blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_range_error();
    test_leading_zero();
    test_mid_slot();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
